// File: rtl/lcd_bram_fetch.sv
// Fetches one frame of LCD characters from a single-port BRAM and hands them to the LCD writer.
// Host writes share the port. Optional LCD_FETCH_BLANK_NUL_EN displays NUL bytes as spaces.
module lcd_bram_fetch #(
  parameter logic [11:0] BASE_ADDR = 12'h000,
  parameter int          NUM_CHARS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  char_data,
  output logic        char_valid,
  input  logic        char_ready,
  output logic        char_line,
  output logic [3:0]  char_pos,
  input  logic        host_wr_req,
  input  logic [11:0] host_addr,
  input  logic [7:0]  host_data,
  output logic        host_wr_ack,
  output logic [11:0] bram_addr,
  output logic [7:0]  bram_di,
  output logic        bram_en,
  output logic        bram_we,
  output logic        bram_ssr,
  input  logic [7:0]  bram_do
);

  // state      | meaning
  // S_IDLE     | waiting for start, port free for host
  // S_RD_ISSUE | fetcher owns the port, read issued
  // S_RD_WAIT  | read data on bram_do, captured at end of cycle
  // S_PRESENT  | character offered until char_ready
  // S_DONE     | frame_done pulse
  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_PRESENT,
    S_DONE
  } state_t;

  localparam logic [4:0] LAST_IDX = 5'(NUM_CHARS - 1);

  state_t      r_state;
  state_t      w_next;
  logic [4:0]  r_index;
  logic [7:0]  r_char_data;
  logic        r_char_valid;
  logic        w_last;
  logic        w_fetch_rd;
  logic        w_host_grant;
  logic [11:0] w_rd_addr;
  logic [7:0]  w_capture;

  assign w_last = (r_index == LAST_IDX);

`ifdef LCD_FETCH_BLANK_NUL_EN
  assign w_capture = (bram_do == 8'h00) ? 8'h20 : bram_do;
`else
  assign w_capture = bram_do;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (start) w_next = S_RD_ISSUE;
      S_RD_ISSUE: w_next = S_RD_WAIT;
      S_RD_WAIT:  w_next = S_PRESENT;
      S_PRESENT:  if (char_ready) w_next = w_last ? S_DONE : S_RD_ISSUE;
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_index      <= 5'd0;
      r_char_data  <= 8'h00;
      r_char_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) r_index <= 5'd0;
        S_RD_WAIT: begin
          r_char_data  <= w_capture;
          r_char_valid <= 1'b1;
        end
        S_PRESENT: if (char_ready) begin
          r_char_valid <= 1'b0;
          if (!w_last) r_index <= r_index + 5'd1;
        end
        default: ;
      endcase
    end
  end

  // Fetcher wins only in RD_ISSUE; reset gating keeps the port quiet while rst_n is low.
  assign w_fetch_rd   = (r_state == S_RD_ISSUE);
  assign w_host_grant = host_wr_req & ~w_fetch_rd & rst_n;
  assign w_rd_addr    = BASE_ADDR + {7'd0, r_index};

  assign host_wr_ack = w_host_grant;
  assign bram_en     = w_fetch_rd | w_host_grant;
  assign bram_we     = w_host_grant;
  assign bram_addr   = w_fetch_rd ? w_rd_addr : host_addr;
  assign bram_di     = host_data;
  assign bram_ssr    = 1'b0;

  assign busy       = (r_state != S_IDLE);
  assign frame_done = (r_state == S_DONE);
  assign char_data  = r_char_data;
  assign char_valid = r_char_valid;
  assign char_line  = r_index[4];
  assign char_pos   = r_index[3:0];

endmodule
